// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone round-robin arbiter.
package wshb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GNT_VGA,
      GNT_STREAM,
      ABORT
   } arb_state_e;

   localparam logic REQ_VGA    = 1'b0;
   localparam logic REQ_STREAM = 1'b1;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; master drives requests, slave drives responses.
interface wshb_if #(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned ADR_W      = 32
);
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [ADR_W-1:0]        adr;
   logic [8*DATA_BYTES-1:0] dat_ms;
   logic [8*DATA_BYTES-1:0] dat_sm;
   logic [DATA_BYTES-1:0]   sel;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic                    ack;
   logic                    err;
   logic                    rty;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wshb_rr_arbiter.sv
// Two-master Wishbone arbiter for the SDRAM port: cycle-long grants, fair alternation
// under contention, watchdog abort of unanswered cycles, and per-master grant counters.
module wshb_rr_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   wshb_if.slave            wshb_ifs_vga,
   wshb_if.slave            wshb_ifs_stream,
   wshb_if.master           wshb_ifm_sdram,
   output logic [CNT_W-1:0] grant_cnt_vga,
   output logic [CNT_W-1:0] grant_cnt_stream,
   output logic             timeout_evt
);

   localparam int unsigned WdW = $clog2(TIMEOUT);
   localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

   arb_state_e       state_q, state_d;
   logic             last_q, last_d;
   logic [WdW-1:0]   wd_q, wd_d;
   logic [CNT_W-1:0] cnt_vga_q, cnt_stream_q;

   logic granted, own_cyc, resp, tmo, enter_vga, enter_stream;

   assign granted      = (state_q == GNT_VGA) || (state_q == GNT_STREAM);
   assign own_cyc      = (state_q == GNT_VGA)    ? wshb_ifs_vga.cyc :
                         (state_q == GNT_STREAM) ? wshb_ifs_stream.cyc : 1'b0;
   assign resp         = wshb_ifm_sdram.ack | wshb_ifm_sdram.err | wshb_ifm_sdram.rty;
   // A response in the final watchdog cycle still rescues the transfer.
   assign tmo          = granted && own_cyc && !resp && (wd_q == WdMax);
   assign enter_vga    = (state_d == GNT_VGA) && (state_q != GNT_VGA);
   assign enter_stream = (state_d == GNT_STREAM) && (state_q != GNT_STREAM);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         last_q       <= REQ_STREAM;
         wd_q         <= '0;
         cnt_vga_q    <= '0;
         cnt_stream_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
         if (enter_vga)    cnt_vga_q    <= cnt_vga_q + 1'b1;
         if (enter_stream) cnt_stream_q <= cnt_stream_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (wshb_ifs_vga.cyc && (!wshb_ifs_stream.cyc || last_q == REQ_STREAM)) begin
               state_d = GNT_VGA;
            end else if (wshb_ifs_stream.cyc) begin
               state_d = GNT_STREAM;
            end
         end
         GNT_VGA: begin
            if (!wshb_ifs_vga.cyc) begin
               last_d  = REQ_VGA;
               state_d = wshb_ifs_stream.cyc ? GNT_STREAM : IDLE;
            end else if (tmo) begin
               last_d  = REQ_VGA;
               state_d = ABORT;
            end
         end
         GNT_STREAM: begin
            if (!wshb_ifs_stream.cyc) begin
               last_d  = REQ_STREAM;
               state_d = wshb_ifs_vga.cyc ? GNT_VGA : IDLE;
            end else if (tmo) begin
               last_d  = REQ_STREAM;
               state_d = ABORT;
            end
         end
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Any state change (entry, release, abort) restarts the watchdog.
      wd_d = (state_d != state_q || resp || !granted) ? '0 : wd_q + 1'b1;
   end

   always_comb begin
      wshb_ifm_sdram.cyc    = 1'b0;
      wshb_ifm_sdram.stb    = 1'b0;
      wshb_ifm_sdram.we     = 1'b0;
      wshb_ifm_sdram.adr    = '0;
      wshb_ifm_sdram.dat_ms = '0;
      wshb_ifm_sdram.sel    = '0;
      wshb_ifm_sdram.cti    = '0;
      wshb_ifm_sdram.bte    = '0;
      wshb_ifs_vga.ack      = 1'b0;
      wshb_ifs_vga.err      = 1'b0;
      wshb_ifs_vga.rty      = 1'b0;
      wshb_ifs_stream.ack   = 1'b0;
      wshb_ifs_stream.err   = 1'b0;
      wshb_ifs_stream.rty   = 1'b0;
      wshb_ifs_vga.dat_sm    = wshb_ifm_sdram.dat_sm;
      wshb_ifs_stream.dat_sm = wshb_ifm_sdram.dat_sm;
      timeout_evt            = tmo;
      unique case (state_q)
         GNT_VGA: begin
            wshb_ifm_sdram.cyc    = wshb_ifs_vga.cyc;
            wshb_ifm_sdram.stb    = wshb_ifs_vga.stb;
            wshb_ifm_sdram.we     = wshb_ifs_vga.we;
            wshb_ifm_sdram.adr    = wshb_ifs_vga.adr;
            wshb_ifm_sdram.dat_ms = wshb_ifs_vga.dat_ms;
            wshb_ifm_sdram.sel    = wshb_ifs_vga.sel;
            wshb_ifm_sdram.cti    = wshb_ifs_vga.cti;
            wshb_ifm_sdram.bte    = wshb_ifs_vga.bte;
            wshb_ifs_vga.ack      = wshb_ifm_sdram.ack;
            wshb_ifs_vga.err      = wshb_ifm_sdram.err | tmo;
            wshb_ifs_vga.rty      = wshb_ifm_sdram.rty;
         end
         GNT_STREAM: begin
            wshb_ifm_sdram.cyc    = wshb_ifs_stream.cyc;
            wshb_ifm_sdram.stb    = wshb_ifs_stream.stb;
            wshb_ifm_sdram.we     = wshb_ifs_stream.we;
            wshb_ifm_sdram.adr    = wshb_ifs_stream.adr;
            wshb_ifm_sdram.dat_ms = wshb_ifs_stream.dat_ms;
            wshb_ifm_sdram.sel    = wshb_ifs_stream.sel;
            wshb_ifm_sdram.cti    = wshb_ifs_stream.cti;
            wshb_ifm_sdram.bte    = wshb_ifs_stream.bte;
            wshb_ifs_stream.ack   = wshb_ifm_sdram.ack;
            wshb_ifs_stream.err   = wshb_ifm_sdram.err | tmo;
            wshb_ifs_stream.rty   = wshb_ifm_sdram.rty;
         end
         default: ;
      endcase
   end

   assign grant_cnt_vga    = cnt_vga_q;
   assign grant_cnt_stream = cnt_stream_q;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Directed bench for wshb_rr_arbiter: burst routing, tie/handover, alternation,
// watchdog abort and mid-cycle reset, each scenario in its own task.
module tb_wshb_rr_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        ack_en  = 1'b0;
   logic [15:0] cnt_v, cnt_s;
   logic        tevt;
   int          checks = 0;
   int          errors = 0;

   always #5 sys_clk = ~sys_clk;

   wshb_if #(.DATA_BYTES(4)) vga_if ();
   wshb_if #(.DATA_BYTES(4)) stream_if ();
   wshb_if #(.DATA_BYTES(4)) sdram_if ();

   // Minimal SDRAM slave: optional zero-wait ack, never err/rty.
   always_comb sdram_if.ack = ack_en & sdram_if.cyc & sdram_if.stb;
   assign sdram_if.err    = 1'b0;
   assign sdram_if.rty    = 1'b0;
   assign sdram_if.dat_sm = 32'hCAFE_0000;

   wshb_rr_arbiter #(
      .TIMEOUT (16),
      .CNT_W   (16)
   ) dut (
      .sys_clk          (sys_clk),
      .sys_rst          (sys_rst),
      .wshb_ifs_vga     (vga_if),
      .wshb_ifs_stream  (stream_if),
      .wshb_ifm_sdram   (sdram_if),
      .grant_cnt_vga    (cnt_v),
      .grant_cnt_stream (cnt_s),
      .timeout_evt      (tevt)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_masters();
      vga_if.cyc = 0; vga_if.stb = 0; vga_if.we = 0; vga_if.adr = 0;
      vga_if.dat_ms = 0; vga_if.sel = 0; vga_if.cti = 0; vga_if.bte = 0;
      stream_if.cyc = 0; stream_if.stb = 0; stream_if.we = 0; stream_if.adr = 0;
      stream_if.dat_ms = 0; stream_if.sel = 0; stream_if.cti = 0; stream_if.bte = 0;
   endtask

   task automatic do_reset();
      idle_masters();
      ack_en  = 0;
      sys_rst = 1;
      tick();
      tick();
      sys_rst = 0;
   endtask

   task automatic test_reset();
      idle_masters();
      sys_rst = 1;
      tick();
      tick();
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b0 || sdram_if.stb !== 1'b0) begin
         errors++;
         $display("FAIL reset_sdram_cyc_stb: got %b%b want 00", sdram_if.cyc, sdram_if.stb);
      end
      checks++;
      if (cnt_v !== 16'd0 || cnt_s !== 16'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_v, cnt_s);
      end
      checks++;
      if (tevt !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout_evt: got %b want 0", tevt);
      end
      checks++;
      if ({vga_if.ack, vga_if.err, vga_if.rty, stream_if.ack, stream_if.err, stream_if.rty}
          !== 6'b0) begin
         errors++;
         $display("FAIL reset_responses: got %b want 000000",
                  {vga_if.ack, vga_if.err, vga_if.rty,
                   stream_if.ack, stream_if.err, stream_if.rty});
      end
      sys_rst = 0;
   endtask

   task automatic test_vga_burst();
      int acks = 0;
      int sacks = 0;
      logic [31:0] exp_adr;
      logic [2:0]  exp_cti;
      do_reset();
      ack_en = 1;
      vga_if.cyc = 1; vga_if.stb = 1; vga_if.sel = 4'hF;
      vga_if.adr = 32'h100; vga_if.cti = 3'b010;
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b0) begin
         errors++;
         $display("FAIL burst_latency: sdram cyc got %b want 0 in request cycle", sdram_if.cyc);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_adr = 32'h100 + 32'(4 * i);
         exp_cti = (i == 7) ? 3'b111 : 3'b010;
         vga_if.adr = exp_adr;
         vga_if.cti = exp_cti;
         settle();
         checks++;
         if (sdram_if.cyc !== 1'b1 || sdram_if.adr !== exp_adr || sdram_if.cti !== exp_cti) begin
            errors++;
            $display("FAIL burst_route beat %0d: got cyc=%b adr=%h cti=%b want 1 %h %b",
                     i, sdram_if.cyc, sdram_if.adr, sdram_if.cti, exp_adr, exp_cti);
         end
         if (vga_if.ack === 1'b1) acks++;
         if (stream_if.ack === 1'b1) sacks++;
      end
      tick();
      vga_if.cyc = 0; vga_if.stb = 0; vga_if.cti = 0;
      tick();
      settle();
      checks++;
      if (acks != 8 || sacks != 0) begin
         errors++;
         $display("FAIL burst_acks: got vga=%0d stream=%0d want 8/0", acks, sacks);
      end
      checks++;
      if (cnt_v !== 16'd1 || cnt_s !== 16'd0) begin
         errors++;
         $display("FAIL burst_counters: got %0d/%0d want 1/0", cnt_v, cnt_s);
      end
      checks++;
      if (sdram_if.cyc !== 1'b0) begin
         errors++;
         $display("FAIL burst_release: sdram cyc got %b want 0", sdram_if.cyc);
      end
   endtask

   task automatic test_tie_isolation();
      int bad = 0;
      do_reset();
      ack_en = 1;
      vga_if.cyc = 1; vga_if.stb = 1; vga_if.we = 0; vga_if.adr = 32'h1000;
      stream_if.cyc = 1; stream_if.stb = 1; stream_if.we = 1; stream_if.adr = 32'hDEAD;
      settle();
      for (int i = 0; i < 6; i++) begin
         tick();
         settle();
         if (sdram_if.adr === 32'hDEAD || sdram_if.we !== 1'b0 || sdram_if.cyc !== 1'b1 ||
             stream_if.ack !== 1'b0 || vga_if.ack !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tie_isolation: got %0d bad cycles want 0", bad);
      end
      vga_if.cyc = 0; vga_if.stb = 0;
      tick();
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b1 || sdram_if.adr !== 32'hDEAD || sdram_if.we !== 1'b1) begin
         errors++;
         $display("FAIL handover: got cyc=%b adr=%h we=%b want 1 0000dead 1",
                  sdram_if.cyc, sdram_if.adr, sdram_if.we);
      end
      checks++;
      if (stream_if.ack !== 1'b1 || vga_if.ack !== 1'b0) begin
         errors++;
         $display("FAIL handover_ack: got stream=%b vga=%b want 1 0", stream_if.ack, vga_if.ack);
      end
      checks++;
      if (cnt_v !== 16'd1 || cnt_s !== 16'd1) begin
         errors++;
         $display("FAIL tie_counters: got %0d/%0d want 1/1", cnt_v, cnt_s);
      end
      idle_masters();
      tick();
      tick();
   endtask

   task automatic test_alternation();
      logic [31:0] exp_adr;
      do_reset();
      ack_en = 1;
      vga_if.adr = 32'h1000; stream_if.adr = 32'h2000;
      vga_if.cyc = 1; vga_if.stb = 1; stream_if.cyc = 1; stream_if.stb = 1;
      for (int g = 0; g < 10; g++) begin
         tick();
         vga_if.cyc = 1; stream_if.cyc = 1;
         settle();
         exp_adr = (g % 2 == 0) ? 32'h1000 : 32'h2000;
         checks++;
         if (sdram_if.cyc !== 1'b1 || sdram_if.adr !== exp_adr) begin
            errors++;
            $display("FAIL alternation grant %0d: got cyc=%b adr=%h want 1 %h",
                     g, sdram_if.cyc, sdram_if.adr, exp_adr);
         end
         tick();
         if (g % 2 == 0) vga_if.cyc = 0;
         else stream_if.cyc = 0;
         settle();
      end
      idle_masters();
      tick();
      tick();
      checks++;
      if (cnt_v !== 16'd5 || cnt_s !== 16'd5) begin
         errors++;
         $display("FAIL alternation_counters: got %0d/%0d want 5/5", cnt_v, cnt_s);
      end
   endtask

   task automatic test_timeout();
      int k = 0;
      logic found = 0;
      do_reset();
      ack_en = 0;
      vga_if.cyc = 1; vga_if.stb = 1; vga_if.adr = 32'h1000;
      stream_if.cyc = 1; stream_if.stb = 1; stream_if.adr = 32'h2000;
      while (k < 40 && !found) begin
         tick();
         settle();
         k++;
         if (tevt === 1'b1) found = 1;
      end
      checks++;
      if (!found || k != 16) begin
         errors++;
         $display("FAIL timeout_latency: got found=%b at granted cycle %0d want 1 at 16",
                  found, k);
      end
      checks++;
      if (vga_if.err !== 1'b1 || stream_if.err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_err: got vga=%b stream=%b want 1 0", vga_if.err, stream_if.err);
      end
      tick();
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b0 || tevt !== 1'b0 || vga_if.err !== 1'b0) begin
         errors++;
         $display("FAIL abort_cycle: got cyc=%b evt=%b err=%b want 0 0 0",
                  sdram_if.cyc, tevt, vga_if.err);
      end
      tick();
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: sdram cyc got %b want 0", sdram_if.cyc);
      end
      tick();
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b1 || sdram_if.adr !== 32'h2000) begin
         errors++;
         $display("FAIL after_abort_grant: got cyc=%b adr=%h want 1 00002000",
                  sdram_if.cyc, sdram_if.adr);
      end
      idle_masters();
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      ack_en = 1;
      vga_if.cyc = 1; vga_if.stb = 1; vga_if.adr = 32'h1000;
      stream_if.cyc = 1; stream_if.stb = 1; stream_if.adr = 32'h2000;
      tick();
      tick();
      vga_if.cyc = 0;
      tick();
      tick();
      settle();
      checks++;
      if (sdram_if.adr !== 32'h2000) begin
         errors++;
         $display("FAIL reset_mid_setup: got adr=%h want 00002000", sdram_if.adr);
      end
      vga_if.cyc = 1;
      sys_rst = 1;
      tick();
      sys_rst = 0;
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b0 || stream_if.ack !== 1'b0 || tevt !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_bus: got cyc=%b ack=%b evt=%b want 0 0 0",
                  sdram_if.cyc, stream_if.ack, tevt);
      end
      checks++;
      if (cnt_v !== 16'd0 || cnt_s !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_counters: got %0d/%0d want 0/0", cnt_v, cnt_s);
      end
      tick();
      settle();
      checks++;
      if (sdram_if.cyc !== 1'b1 || sdram_if.adr !== 32'h1000) begin
         errors++;
         $display("FAIL reset_mid_tie: got cyc=%b adr=%h want 1 00001000",
                  sdram_if.cyc, sdram_if.adr);
      end
      idle_masters();
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_vga_burst();
      test_tie_isolation();
      test_alternation();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no finish want finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/wshb_rr_arbiter.md
# wshb_rr_arbiter

Two-master Wishbone arbiter that shares the single SDRAM slave port of the hardware support block between the VGA frame reader and the video stream writer. It holds a grant for the full duration of a master's `cyc`, alternates fairly under contention, and aborts stuck cycles with a watchdog. It also counts grants per master for debug LEDs. It sits between the `vga` and stream masters and `hw_support` in the `sys_clk` domain.

## Interface
- `TIMEOUT`, 1024: cycles of granted `cyc` with no `ack`/`err`/`rty` before watchdog abort; ≥ 2
- `CNT_W`, 16: width of grant counters
- `sys_clk`  in  1  system clock (100 MHz); the only clock
- `sys_rst`  in  1  synchronous, active-high reset
- `wshb_ifs_vga`  wshb_if.slave  DATA_BYTES=4  requester 0 (VGA reader)
- `wshb_ifs_stream`  wshb_if.slave  DATA_BYTES=4  requester 1 (stream writer)
- `wshb_ifm_sdram`  wshb_if.master  DATA_BYTES=4  shared SDRAM slave
- `grant_cnt_vga`  out  CNT_W  number of grants issued to requester 0, wrapping
- `grant_cnt_stream`  out  CNT_W  number of grants issued to requester 1, wrapping
- `timeout_evt`  out  1  one-cycle pulse on each watchdog abort

## Operation
- FSM states: `IDLE`, `GNT_VGA`, `GNT_STREAM`, `ABORT`. Registered; reset → `IDLE`, `last` pointer → stream (so VGA wins the first tie).
- `IDLE`: if exactly one `cyc` high → grant it; both high → grant the one not equal to `last`; none → stay.
- `GNT_x`: routes master x's `cyc, stb, we, adr, dat_ms, sel, cti, bte` to SDRAM; SDRAM `ack, err, rty` to x only. `dat_sm` fans out to both masters unconditionally.
- Non-granted master sees `ack=err=rty=0`.
- In `IDLE`/`ABORT`: SDRAM `cyc=stb=we=0`, `adr`, `dat_ms`, `sel`, `cti`, `bte` = 0.
- Release: when granted master's `cyc` is sampled 0, `last` ← x. If the other master's `cyc` is 1 that same cycle, go directly to its `GNT` state (no idle bubble); otherwise go to `IDLE`.
- Grant counter of x increments (wrap at 2^CNT_W) on every entry into `GNT_x`.
- Watchdog: counter cleared on grant entry and on any `ack|err|rty`; increments while granted. At `TIMEOUT-1`: drive `err=1` to the granted master for that cycle, pulse `timeout_evt`, and go to `ABORT`.
- `ABORT` lasts exactly 1 cycle (SDRAM `cyc` low), then → `IDLE`; `last` ← aborted master.
- Reset mid-cycle: all outputs take their reset values in the next cycle; outstanding SDRAM cycle is dropped (SDRAM `cyc` low).

## Timing
- Arbitration latency: `cyc` rises in cycle n while `IDLE` → SDRAM `cyc/stb` driven in n+1.
- Routing of request and response signals is combinational from the registered state: zero added latency on `ack`, `stb` and data once granted.
- Handover: owner `cyc` low in cycle n → other master owns SDRAM in n+1.
- `timeout_evt`/`err`: asserted in the cycle where the watchdog count equals `TIMEOUT-1`, i.e. `TIMEOUT` cycles after the last response or after grant entry.
- Reset values: counters 0, `timeout_evt` 0, all slave-side responses 0, SDRAM `cyc/stb` 0.

## Structure
- Package `wshb_arb_pkg`: state enum (`IDLE`, `GNT_VGA`, `GNT_STREAM`, `ABORT`) and requester index constants `REQ_VGA=0`, `REQ_STREAM=1`.
- Single module; no sub-module. Watchdog counter width is `$clog2(TIMEOUT)`.
- Replaces the direct SDRAM connection in the top level. The stream interface keeps its current role.

## Test plan
- VGA only, 8-beat burst (`cti=010`, then `111`), SDRAM ack every cycle → grant 1 cycle after `cyc`, 8 acks to VGA, none to stream, `grant_cnt_vga=1`.
- Both `cyc` rise together after reset → VGA granted first. On VGA `cyc` drop, stream is granted next cycle with no IDLE cycle. Counters are 1/1.
- Stream repeatedly re-requests while VGA also waits → strict alternation over 10 grants, 5 each.
- SDRAM never acks, `TIMEOUT=16` → `err` to granted master and `timeout_evt` 16 cycles after grant, then 1 `ABORT` cycle with SDRAM `cyc=0`, then the other waiting master is granted.
- `sys_rst` asserted mid-burst → next cycle SDRAM `cyc=0`, all counters 0, state `IDLE`; after release, VGA wins a tie.
- Non-granted master holds `stb=1`, `we=1`, `adr=0xDEAD` throughout → never appears on SDRAM bus, receives no `ack`.
